lfsr_stream_checker: RTL and testbench

//  Receive side of the LFSR message stream: accepts words produced by the lfsr primitive,

---
 rtl/lfsr_stream_checker_pkg.sv | 22 ++
 rtl/lfsr_stream_checker_if.sv | 13 +
 rtl/lfsr_stream_checker_step.sv | 15 +
 rtl/lfsr_stream_checker.sv | 156 +++++++++++++++
 tb/tb_lfsr_stream_checker.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/lfsr_stream_checker_pkg.sv
// Shared constants for the LFSR stream checker: word width, feedback taps,
// counter width, FSM state encodings and a saturating increment helper.
package lfsr_stream_checker_pkg;

  localparam int          DEF_WIDTH = 64;
  // x^64 + x^63 + x^61 + x^60 + 1 -> bits 63, 62, 60, 59
  localparam logic [63:0] DEF_TAPS  = 64'hD800_0000_0000_0000;

  localparam int               CNT_W   = 19;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEED  = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/lfsr_stream_checker_if.sv
// Word stream handshake: a beat happens when in_valid and in_ready are both high.
interface lfsr_stream_checker_if #(
  parameter int WIDTH = 64
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_word;
  logic             in_ready;

  modport master (output in_valid, output in_word, input  in_ready);
  modport slave  (input  in_valid, input  in_word, output in_ready);

endinterface

// File: rtl/lfsr_stream_checker_step.sv
// One LFSR advance: shift left, parity of the tapped bits enters bit 0.
// The generator uses the same module so both ends share identical feedback.
module lfsr_step
  import lfsr_stream_checker_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS
) (
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_next
);

  assign o_next = {i_x[WIDTH-2:0], ^(i_x & TAPS)};

endmodule

// File: rtl/lfsr_stream_checker.sv
// Receive side of the LFSR message stream. The first non-zero word of a run
// seeds the predictor; every later word is compared with the prediction and
// counted. Too many consecutive misses drop lock and the next word re-seeds.
module lfsr_stream_checker
  import lfsr_stream_checker_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS     = DEF_TAPS,
  parameter int               TEST_LEN = 1000,
  parameter int               LOSS_THR = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  lfsr_stream_checker_if.slave  s_stream,
  output logic                  o_locked,
  output logic                  o_err_pulse,
  output logic [CNT_W-1:0]      o_nb_words,
  output logic [CNT_W-1:0]      o_nb_errors,
  output logic                  o_done
);

  logic [1:0]       r_state,    w_state_next;
  logic             r_ready,    w_ready_next;
  logic             r_locked,   w_locked_next;
  logic             r_err,      w_err_next;
  logic             r_done,     w_done_next;
  logic [CNT_W-1:0] r_words,    w_words_next;
  logic [CNT_W-1:0] r_errors,   w_errors_next;
  logic [WIDTH-1:0] r_expected, w_expected_next;
  logic [3:0]       r_miss,     w_miss_next;

  logic             w_beat;
  logic [3:0]       w_miss_inc;
  logic [WIDTH-1:0] w_seed_step;
  logic [WIDTH-1:0] w_exp_step;

  // Prediction from a fresh seed word and from the running expectation.
  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step_seed (
    .i_x    (s_stream.in_word),
    .o_next (w_seed_step)
  );

  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step_track (
    .i_x    (r_expected),
    .o_next (w_exp_step)
  );

  assign w_beat     = s_stream.in_valid & r_ready;
  assign w_miss_inc = r_miss + 4'd1;

  // Next-state logic: start has priority over a beat in the same cycle.
  always_comb begin
    w_state_next    = r_state;
    w_locked_next   = r_locked;
    w_err_next      = 1'b0;
    w_words_next    = r_words;
    w_errors_next   = r_errors;
    w_expected_next = r_expected;
    w_miss_next     = r_miss;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        // Locked is deliberately left alone here; it is held through DONE.
        if (i_start) begin
          w_state_next  = ST_SEED;
          w_words_next  = '0;
          w_errors_next = '0;
          w_miss_next   = '0;
        end
      end

      ST_SEED, ST_TRACK: begin
        if (i_start) begin
          w_state_next  = ST_SEED;
          w_words_next  = '0;
          w_errors_next = '0;
          w_miss_next   = '0;
          w_locked_next = 1'b0;
        end else if (w_beat) begin
          w_words_next = sat_inc(r_words);
          if (r_state == ST_SEED) begin
            // All-zero is the LFSR lock-up word and cannot seed.
            if (s_stream.in_word == '0) begin
              w_err_next = 1'b1;
            end else begin
              w_expected_next = w_seed_step;
              w_locked_next   = 1'b1;
              w_state_next    = ST_TRACK;
            end
          end else begin
            // Prediction advances on every beat; a miss never resyncs.
            w_expected_next = w_exp_step;
            if (s_stream.in_word == r_expected) begin
              w_miss_next = '0;
            end else begin
              w_err_next = 1'b1;
              if (w_miss_inc == 4'(LOSS_THR)) begin
                w_miss_next   = '0;
                w_locked_next = 1'b0;
                w_state_next  = ST_SEED;
              end else begin
                w_miss_next = w_miss_inc;
              end
            end
          end
          if (w_err_next) begin
            w_errors_next = sat_inc(r_errors);
          end
          // The last word of the run ends it regardless of the compare result.
          if (w_words_next == CNT_W'(TEST_LEN)) begin
            w_state_next = ST_DONE;
          end
        end
      end

      default: w_state_next = ST_IDLE;
    endcase

    w_ready_next = (w_state_next == ST_SEED) || (w_state_next == ST_TRACK);
    w_done_next  = (w_state_next == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      r_words    <= '0;
      r_errors   <= '0;
      r_expected <= '0;
      r_miss     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ready    <= w_ready_next;
      r_locked   <= w_locked_next;
      r_err      <= w_err_next;
      r_done     <= w_done_next;
      r_words    <= w_words_next;
      r_errors   <= w_errors_next;
      r_expected <= w_expected_next;
      r_miss     <= w_miss_next;
    end
  end

  assign s_stream.in_ready = r_ready;
  assign o_locked          = r_locked;
  assign o_err_pulse       = r_err;
  assign o_nb_words        = r_words;
  assign o_nb_errors       = r_errors;
  assign o_done            = r_done;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker with a short run length (8 words).
// A table of one-cycle stimulus rows with expected outputs after each edge,
// plus hand-written reset sequences.
module tb_lfsr_stream_checker;
  import lfsr_stream_checker_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] nb_words;
  logic [CNT_W-1:0] nb_errors;
  logic             done;

  int checks;
  int failures;

  lfsr_stream_checker_if #(.WIDTH(64)) stream_if ();

  lfsr_stream_checker #(
    .WIDTH    (64),
    .TAPS     (64'hD800_0000_0000_0000),
    .TEST_LEN (8),
    .LOSS_THR (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .s_stream    (stream_if),
    .o_locked    (locked),
    .o_err_pulse (err_pulse),
    .o_nb_words  (nb_words),
    .o_nb_errors (nb_errors),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        valid;
    logic [63:0] word;
    logic        ready;
    logic        locked;
    logic        err;
    logic        done;
    logic [18:0] words;
    logic [18:0] errors;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic v, input logic [63:0] w,
                              input logic rdy, input logic lk, input logic er,
                              input logic dn, input int nw, input int ne);
    vec_t r;
    r.start  = s;   r.valid  = v;   r.word = w;
    r.ready  = rdy; r.locked = lk;  r.err  = er; r.done = dn;
    r.words  = 19'(nw);
    r.errors = 19'(ne);
    return r;
  endfunction

  task automatic check_all(input string name, input logic rdy, input logic lk,
                           input logic er, input logic dn,
                           input logic [18:0] nw, input logic [18:0] ne);
    logic [41:0] got;
    logic [41:0] exp;
    got = {stream_if.in_ready, locked, err_pulse, done, nb_words, nb_errors};
    exp = {rdy, lk, er, dn, nw, ne};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got ready=%b locked=%b err=%b done=%b words=%0d errors=%0d, required ready=%b locked=%b err=%b done=%b words=%0d errors=%0d",
               name, stream_if.in_ready, locked, err_pulse, done, nb_words, nb_errors,
               rdy, lk, er, dn, nw, ne);
    end else begin
      $display("ok   %s: ready=%b locked=%b err=%b done=%b words=%0d errors=%0d",
               name, rdy, lk, er, dn, nw, ne);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    stream_if.in_valid = 1'b0;
    stream_if.in_word  = '0;

    // Reset state while rst_n is held low.
    #22;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all("idle_no_start", 0, 0, 0, 0, 0, 0);

    // Idle: a valid word without start is not accepted.
    vecs.push_back(mk(0,1,64'h1,               0,0,0,0,0,0));
    // Basic tracking 1,2,4,8.
    vecs.push_back(mk(1,0,64'h0,               1,0,0,0,0,0));
    vecs.push_back(mk(0,1,64'h1,               1,1,0,0,1,0));
    vecs.push_back(mk(0,1,64'h2,               1,1,0,0,2,0));
    vecs.push_back(mk(0,1,64'h4,               1,1,0,0,3,0));
    vecs.push_back(mk(0,1,64'h8,               1,1,0,0,4,0));
    // Wrap: top bit feeds back into bit 0.
    vecs.push_back(mk(1,0,64'h0,               1,0,0,0,0,0));
    vecs.push_back(mk(0,1,64'h8000_0000_0000_0000, 1,1,0,0,1,0));
    vecs.push_back(mk(0,1,64'h1,               1,1,0,0,2,0));
    // Single error, prediction keeps advancing.
    vecs.push_back(mk(1,0,64'h0,               1,0,0,0,0,0));
    vecs.push_back(mk(0,1,64'h1,               1,1,0,0,1,0));
    vecs.push_back(mk(0,1,64'h3,               1,1,1,0,2,1));
    vecs.push_back(mk(0,1,64'h4,               1,1,0,0,3,1));
    vecs.push_back(mk(0,0,64'h8,               1,1,0,0,3,1));
    // Loss of lock after four consecutive misses, then re-seed.
    vecs.push_back(mk(1,0,64'h0,               1,0,0,0,0,0));
    vecs.push_back(mk(0,1,64'h1,               1,1,0,0,1,0));
    vecs.push_back(mk(0,1,64'hFF,              1,1,1,0,2,1));
    vecs.push_back(mk(0,1,64'hFF,              1,1,1,0,3,2));
    vecs.push_back(mk(0,1,64'hFF,              1,1,1,0,4,3));
    vecs.push_back(mk(0,1,64'hFF,              1,0,1,0,5,4));
    vecs.push_back(mk(0,1,64'h10,              1,1,0,0,6,4));
    vecs.push_back(mk(0,1,64'h20,              1,1,0,0,7,4));
    // Full run of 8 words to DONE.
    vecs.push_back(mk(1,0,64'h0,               1,0,0,0,0,0));
    for (int i = 0; i < 7; i++) begin
      vecs.push_back(mk(0,1,64'h1 << i,        1,1,0,0,i+1,0));
    end
    vecs.push_back(mk(0,1,64'h80,              0,1,0,1,8,0));
    vecs.push_back(mk(0,1,64'h100,             0,1,0,1,8,0));
    // New run from DONE, illegal zero seed, then start aborting TRACK.
    vecs.push_back(mk(1,0,64'h0,               1,1,0,0,0,0));
    vecs.push_back(mk(0,1,64'h0,               1,1,1,0,1,1));
    vecs.push_back(mk(0,1,64'h5,               1,1,0,0,2,1));
    vecs.push_back(mk(0,1,64'hA,               1,1,0,0,3,1));
    vecs.push_back(mk(1,1,64'h14,              1,0,0,0,0,0));
    vecs.push_back(mk(0,1,64'h14,              1,1,0,0,1,0));

    foreach (vecs[k]) begin
      start              = vecs[k].start;
      stream_if.in_valid = vecs[k].valid;
      stream_if.in_word  = vecs[k].word;
      @(posedge clk);
      #1;
      check_all($sformatf("row%0d word=%h", k, vecs[k].word),
                vecs[k].ready, vecs[k].locked, vecs[k].err, vecs[k].done,
                vecs[k].words, vecs[k].errors);
    end
    start              = 1'b0;
    stream_if.in_valid = 1'b0;

    // Asynchronous reset mid-run clears everything before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stream_if.in_valid = 1'b1;
    stream_if.in_word  = 64'h1;
    @(posedge clk);
    #1;
    check_all("after_reset_idle", 0, 0, 0, 0, 0, 0);
    stream_if.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
